// File: rtl/load_read_if.sv
// Load request, data-memory read port and write-back handshake of load_read_unit.
// Optional BYTE_LOAD_EN adds the req_byte/req_signed request qualifiers.
interface load_read_if #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned REG_ADDR_W = 6
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic [REG_ADDR_W-1:0] req_dest;
`ifdef BYTE_LOAD_EN
    logic                  req_byte;
    logic                  req_signed;
`endif
    logic                  mem_read_en;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_read_data;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [DATA_W-1:0]     wb_data;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic                  reg_write;

    // Load unit side.
    modport slave (
`ifdef BYTE_LOAD_EN
        input  req_byte, req_signed,
`endif
        input  req_valid, req_addr, req_dest, mem_read_data, wb_ready,
        output req_ready, mem_read_en, mem_addr, wb_valid, wb_data, wb_dest, reg_write
    );

    // Requester / memory / write-back side.
    modport master (
`ifdef BYTE_LOAD_EN
        output req_byte, req_signed,
`endif
        output req_valid, req_addr, req_dest, mem_read_data, wb_ready,
        input  req_ready, mem_read_en, mem_addr, wb_valid, wb_data, wb_dest, reg_write
    );
endinterface

// File: rtl/load_read_unit.sv
// Single-outstanding load unit: issues a data-memory read, waits READ_LATENCY cycles,
// returns the word to write-back. BYTE_LOAD_EN enables byte loads with sign/zero extension.
module load_read_unit #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned REG_ADDR_W   = 6,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    load_read_if.slave  bus,
    output logic        busy
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BYTE_W = 8;

    if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_latency
        $error("load_read_unit: READ_LATENCY must be within 1..15");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [REG_ADDR_W-1:0] wb_dest_q, wb_dest_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;
    logic                  req_ready_q, req_ready_d;
    logic                  mem_read_en_q, mem_read_en_d;
    logic                  wb_valid_q, wb_valid_d;
    logic                  busy_q, busy_d;
    logic                  reg_write_c;
    logic [DATA_W-1:0]     load_data;

`ifdef BYTE_LOAD_EN
    logic              byte_q, byte_d;
    logic              signed_q, signed_d;
    logic              lane_q, lane_d;
    logic [BYTE_W-1:0] sel_byte;

    // Lane select and extension of the returned word for byte loads.
    always_comb begin
        sel_byte  = lane_q ? bus.mem_read_data[2*BYTE_W-1:BYTE_W] : bus.mem_read_data[BYTE_W-1:0];
        load_data = bus.mem_read_data;
        if (byte_q) begin
            load_data = signed_q ? {{(DATA_W-BYTE_W){sel_byte[BYTE_W-1]}}, sel_byte}
                                 : {{(DATA_W-BYTE_W){1'b0}}, sel_byte};
        end
    end
`else
    assign load_data = bus.mem_read_data;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        wb_dest_d   = wb_dest_q;
        wb_data_d   = wb_data_q;
        reg_write_c = 1'b0;
`ifdef BYTE_LOAD_EN
        byte_d      = byte_q;
        signed_d    = signed_q;
        lane_d      = lane_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
`ifdef BYTE_LOAD_EN
                    mem_addr_d = ADDR_W'(bus.req_addr >> 1);
                    lane_d     = bus.req_addr[0];
                    byte_d     = bus.req_byte;
                    signed_d   = bus.req_signed;
`else
                    mem_addr_d = bus.req_addr;
`endif
                    wb_dest_d  = bus.req_dest;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(READ_LATENCY);
                state_d = WAIT;
            end
            WAIT: begin
                // Counter hits zero on the capture edge, READ_LATENCY edges after ISSUE.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    wb_data_d = load_data;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (bus.wb_ready) begin
                    reg_write_c = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d   = (state_d == IDLE);
        mem_read_en_d = (state_d == ISSUE);
        wb_valid_d    = (state_d == RESP);
        busy_d        = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mem_addr_q    <= '0;
            wb_dest_q     <= '0;
            wb_data_q     <= '0;
            req_ready_q   <= 1'b1;
            mem_read_en_q <= 1'b0;
            wb_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
`ifdef BYTE_LOAD_EN
            byte_q        <= 1'b0;
            signed_q      <= 1'b0;
            lane_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_addr_q    <= mem_addr_d;
            wb_dest_q     <= wb_dest_d;
            wb_data_q     <= wb_data_d;
            req_ready_q   <= req_ready_d;
            mem_read_en_q <= mem_read_en_d;
            wb_valid_q    <= wb_valid_d;
            busy_q        <= busy_d;
`ifdef BYTE_LOAD_EN
            byte_q        <= byte_d;
            signed_q      <= signed_d;
            lane_q        <= lane_d;
`endif
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.mem_read_en = mem_read_en_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_dest     = wb_dest_q;
    // Write enable is the handshake itself, so it cannot outlive the RESP cycle.
    assign bus.reg_write   = reg_write_c;
    assign busy            = busy_q;
endmodule
